// File: rtl/pipe_control_unit.sv
// Pipelined MIPS control: ID decode, EX/MEM/WB control bundle registers, mult/div interlock.
// Define MULDIV_EN to decode mult/div/mfhi/mflo and build the HI/LO busy counter.
module pipe_control_unit #(
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned MULDIV_LAT = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  stall_in,
    input  logic                  flush_ex,
    output logic                  branch_id,
    output logic                  jump_id,
    output logic                  jrsrc_id,
    output logic                  stall_out,
    output logic                  illegal_id,
    output logic                  reg_dst_ex,
    output logic                  alu_src_ex,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_ex,
    output logic                  jalsrc_ex,
    output logic [1:0]            hilo_sel_ex,
    output logic                  we_dm_mem,
    output logic                  we_reg_wb,
    output logic                  dm2reg_wb,
    output logic                  muldiv_start,
    output logic                  muldiv_busy
);

    localparam logic [ALU_CTRL_W-1:0] AluAnd = ALU_CTRL_W'(4'b0000);
    localparam logic [ALU_CTRL_W-1:0] AluOr  = ALU_CTRL_W'(4'b0001);
    localparam logic [ALU_CTRL_W-1:0] AluAdd = ALU_CTRL_W'(4'b0010);
    localparam logic [ALU_CTRL_W-1:0] AluSub = ALU_CTRL_W'(4'b0110);
    localparam logic [ALU_CTRL_W-1:0] AluSlt = ALU_CTRL_W'(4'b0111);

    // A zero latency would never raise busy, so the interlock would be meaningless.
    if (MULDIV_LAT == 0) begin : g_bad_lat
        $error("MULDIV_LAT must be at least 1");
    end

    typedef struct packed {
        logic                  reg_dst;
        logic                  alu_src;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic                  jalsrc;
        logic [1:0]            hilo_sel;
        logic                  we_dm;
        logic                  we_reg;
        logic                  dm2reg;
    } ctrl_t;

    ctrl_t dec;
    ctrl_t ex_d, ex_q;
    logic  mem_we_dm_q, mem_we_reg_q, mem_dm2reg_q;
    logic  wb_we_reg_q, wb_dm2reg_q;

`ifdef MULDIV_EN
    logic muldiv_op;
    logic hilo_dep;
`endif

    always_comb begin
        dec        = '0;
        branch_id  = 1'b0;
        jump_id    = 1'b0;
        jrsrc_id   = 1'b0;
        illegal_id = 1'b0;
`ifdef MULDIV_EN
        muldiv_op  = 1'b0;
        hilo_dep   = 1'b0;
`endif
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20: begin dec.reg_dst = 1'b1; dec.we_reg = 1'b1; dec.alu_ctrl = AluAdd; end
                    6'h22: begin dec.reg_dst = 1'b1; dec.we_reg = 1'b1; dec.alu_ctrl = AluSub; end
                    6'h24: begin dec.reg_dst = 1'b1; dec.we_reg = 1'b1; dec.alu_ctrl = AluAnd; end
                    6'h25: begin dec.reg_dst = 1'b1; dec.we_reg = 1'b1; dec.alu_ctrl = AluOr;  end
                    6'h2A: begin dec.reg_dst = 1'b1; dec.we_reg = 1'b1; dec.alu_ctrl = AluSlt; end
                    6'h08: jrsrc_id = 1'b1;
`ifdef MULDIV_EN
                    6'h10: begin
                        dec.reg_dst  = 1'b1;
                        dec.we_reg   = 1'b1;
                        dec.hilo_sel = 2'b01;
                        hilo_dep     = 1'b1;
                    end
                    6'h12: begin
                        dec.reg_dst  = 1'b1;
                        dec.we_reg   = 1'b1;
                        dec.hilo_sel = 2'b10;
                        hilo_dep     = 1'b1;
                    end
                    6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        muldiv_op = 1'b1;
                        hilo_dep  = 1'b1;
                    end
`endif
                    default: illegal_id = 1'b1;
                endcase
            end
            6'h23: begin
                dec.alu_src  = 1'b1;
                dec.we_reg   = 1'b1;
                dec.dm2reg   = 1'b1;
                dec.alu_ctrl = AluAdd;
            end
            6'h2B: begin dec.alu_src = 1'b1; dec.we_dm = 1'b1; dec.alu_ctrl = AluAdd; end
            6'h04: begin branch_id = 1'b1; dec.alu_ctrl = AluSub; end
            6'h08: begin dec.alu_src = 1'b1; dec.we_reg = 1'b1; dec.alu_ctrl = AluAdd; end
            6'h02: jump_id = 1'b1;
            6'h03: begin jump_id = 1'b1; dec.jalsrc = 1'b1; dec.we_reg = 1'b1; end
            default: illegal_id = 1'b1;
        endcase
    end

`ifdef MULDIV_EN
    localparam int unsigned CntW = $clog2(MULDIV_LAT + 1);

    logic [CntW-1:0] cnt_q;

    assign muldiv_busy  = (cnt_q != '0);
    assign stall_out    = stall_in | (muldiv_busy & hilo_dep);
    assign muldiv_start = muldiv_op & ~stall_out & ~flush_ex;

    // stall_in deliberately does not pause the count; the unit runs independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (muldiv_start) begin
            cnt_q <= CntW'(MULDIV_LAT);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end
`else
    assign muldiv_busy  = 1'b0;
    assign stall_out    = stall_in;
    assign muldiv_start = 1'b0;
`endif

    assign ex_d = (stall_out || flush_ex) ? '0 : dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= '0;
            mem_we_dm_q  <= 1'b0;
            mem_we_reg_q <= 1'b0;
            mem_dm2reg_q <= 1'b0;
            wb_we_reg_q  <= 1'b0;
            wb_dm2reg_q  <= 1'b0;
        end else begin
            ex_q         <= ex_d;
            mem_we_dm_q  <= ex_q.we_dm;
            mem_we_reg_q <= ex_q.we_reg;
            mem_dm2reg_q <= ex_q.dm2reg;
            wb_we_reg_q  <= mem_we_reg_q;
            wb_dm2reg_q  <= mem_dm2reg_q;
        end
    end

    assign reg_dst_ex  = ex_q.reg_dst;
    assign alu_src_ex  = ex_q.alu_src;
    assign alu_ctrl_ex = ex_q.alu_ctrl;
    assign jalsrc_ex   = ex_q.jalsrc;
    assign hilo_sel_ex = ex_q.hilo_sel;
    assign we_dm_mem   = mem_we_dm_q;
    assign we_reg_wb   = wb_we_reg_q;
    assign dm2reg_wb   = wb_dm2reg_q;

endmodule
